// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg
//   Shared types for the commit trace buffer.
//   rec_t   : one retired-instruction record as queued and presented to the
//             trace consumer (pc, inst, regfile write, memory access, halt,
//             instruction number).
//   state_t : buffer lifecycle RUN -> DRAIN -> DONE.
//   Optional build macro used by the top: COMMIT_CYCLE_STAMP_EN.
package commit_trace_pkg;

    // Width of the instruction number carried in each record.
    localparam int unsigned INUM_W = 32;

    typedef struct packed {
        logic [15:0]       pc;
        logic [15:0]       inst;
        logic              regwr;
        logic [2:0]        wreg;
        logic [15:0]       wdata;
        logic              memrd;
        logic              memwr;
        logic [15:0]       addr;
        logic [15:0]       mdata;
        logic              halt;
        logic [INUM_W-1:0] inum;
    } rec_t;

    localparam int unsigned REC_W = $bits(rec_t);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo
//   Register-based FIFO, DEPTH entries of WIDTH bits. Pointers carry one
//   extra wrap bit so full and empty are distinguished without a counter.
//   A push while full is accepted only when a pop happens in the same cycle.
//   Ports:
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     push, wrData    write request and data
//     pop             remove head (ignored when empty)
//     rdData          head entry, zero while empty
//     full, empty     occupancy flags
module trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wrData,
    input  logic             pop,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    // Head gated to zero so an empty FIFO presents an all-zero record.
    assign rdData = empty ? '0 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    // Storage needs no reset: contents are only visible through rdData,
    // which is masked while empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures one retire record per cycle from the writeback/memory boundary,
//   numbers every captured instruction and queues records for a slow
//   consumer draining over valid/ready.
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     cap_en              retire record presented this cycle
//     cap_pc/inst         PC and instruction word
//     cap_regwr/wreg/wdata register file write
//     cap_memrd/memwr/addr/mdata data-memory access
//     cap_halt            halt retiring
//     out_valid/out_ready head handshake
//     out_rec             head record (fields above + inum)
//     out_cycle           capture cycle of head (zero unless stamping built in)
//     overflow            sticky: a record was dropped on a full FIFO
//     done                halt captured and FIFO drained
//   Build macro COMMIT_CYCLE_STAMP_EN: store the cycle counter with each
//   entry and present it on out_cycle.
import commit_trace_pkg::*;

module commit_trace_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic [15:0]      cap_pc,
    input  logic [15:0]      cap_inst,
    input  logic             cap_regwr,
    input  logic [2:0]       cap_wreg,
    input  logic [15:0]      cap_wdata,
    input  logic             cap_memrd,
    input  logic             cap_memwr,
    input  logic [15:0]      cap_addr,
    input  logic [15:0]      cap_mdata,
    input  logic             cap_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output rec_t             out_rec,
    output logic [CNT_W-1:0] out_cycle,
    output logic             overflow,
    output logic             done
);

`ifdef COMMIT_CYCLE_STAMP_EN
    localparam int unsigned FIFO_W = REC_W + CNT_W;
`else
    localparam int unsigned FIFO_W = REC_W;
`endif

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] inumCnt;
    logic [CNT_W-1:0] cycleCnt;
    logic             capture;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    rec_t             capRec;
    logic [FIFO_W-1:0] wrData;
    logic [FIFO_W-1:0] rdData;

    assign capture   = cap_en & (state == RUN);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A capture into a full FIFO still fits if the head leaves this cycle.
    assign push      = capture & (~full | pop);
    assign done      = (state == DONE);

    always_comb begin
        capRec       = '0;
        capRec.pc    = cap_pc;
        capRec.inst  = cap_inst;
        capRec.regwr = cap_regwr;
        capRec.wreg  = cap_wreg;
        capRec.wdata = cap_wdata;
        capRec.memrd = cap_memrd;
        capRec.memwr = cap_memwr;
        capRec.addr  = cap_addr;
        capRec.mdata = cap_mdata;
        capRec.halt  = cap_halt;
        capRec.inum  = INUM_W'(inumCnt);
    end

`ifdef COMMIT_CYCLE_STAMP_EN
    assign wrData    = {capRec, cycleCnt};
    assign out_rec   = rdData[FIFO_W-1:CNT_W];
    assign out_cycle = rdData[CNT_W-1:0];
`else
    assign wrData    = capRec;
    assign out_rec   = rdData;
    assign out_cycle = '0;
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wrData (wrData),
        .pop    (pop),
        .rdData (rdData),
        .full   (full),
        .empty  (empty)
    );

    // Instruction number advances on every captured record, dropped or not,
    // so a consumer sees a gap in inum where records were lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inumCnt  <= '0;
            cycleCnt <= '0;
            overflow <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 1'b1;
            if (capture) inumCnt <= inumCnt + 1'b1;
            if (capture && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= nextState;
    end

    // A halt record moves to DRAIN even when it was dropped on a full FIFO.
    always_comb begin
        nextState = state;
        unique case (state)
            RUN:     if (cap_en && cap_halt) nextState = DRAIN;
            DRAIN:   if (empty) nextState = DONE;
            DONE:    nextState = DONE;
            default: nextState = RUN;
        endcase
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
import commit_trace_pkg::*;

module tb_commit_trace_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cap_en = 1'b0;
    logic [15:0]      cap_pc = '0;
    logic [15:0]      cap_inst = '0;
    logic             cap_regwr = 1'b0;
    logic [2:0]       cap_wreg = '0;
    logic [15:0]      cap_wdata = '0;
    logic             cap_memrd = 1'b0;
    logic             cap_memwr = 1'b0;
    logic [15:0]      cap_addr = '0;
    logic [15:0]      cap_mdata = '0;
    logic             cap_halt = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    rec_t             out_rec;
    logic [CNT_W-1:0] out_cycle;
    logic             overflow;
    logic             done;

    always #5 clk = ~clk;

    commit_trace_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (cap_en),
        .cap_pc    (cap_pc),
        .cap_inst  (cap_inst),
        .cap_regwr (cap_regwr),
        .cap_wreg  (cap_wreg),
        .cap_wdata (cap_wdata),
        .cap_memrd (cap_memrd),
        .cap_memwr (cap_memwr),
        .cap_addr  (cap_addr),
        .cap_mdata (cap_mdata),
        .cap_halt  (cap_halt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rec   (out_rec),
        .out_cycle (out_cycle),
        .overflow  (overflow),
        .done      (done)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Scoreboard: expected FIFO contents and stamps, plus model counters.
    rec_t             expQ[$];
    logic [CNT_W-1:0] expCycQ[$];
    logic [CNT_W-1:0] mInum;
    logic [CNT_W-1:0] mCycle;
    logic             mOvf;
    state_t           mState;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setIdle();
        cap_en    = 1'b0;
        cap_halt  = 1'b0;
        // Garbage on the other inputs: they must be ignored while cap_en=0.
        cap_pc    = 16'($urandom);
        cap_inst  = 16'($urandom);
        cap_regwr = 1'($urandom);
        cap_wreg  = 3'($urandom);
        cap_wdata = 16'($urandom);
        cap_memrd = 1'($urandom);
        cap_memwr = 1'($urandom);
        cap_addr  = 16'($urandom);
        cap_mdata = 16'($urandom);
    endtask

    task automatic setCap(input logic [15:0] pc, input logic [15:0] inst, input logic regwr,
                          input logic memrd, input logic memwr, input logic halt);
        cap_en    = 1'b1;
        cap_pc    = pc;
        cap_inst  = inst;
        cap_regwr = regwr;
        cap_wreg  = pc[2:0];
        cap_wdata = pc ^ 16'h5a5a;
        cap_memrd = memrd;
        cap_memwr = memwr;
        cap_addr  = inst ^ 16'h0f0f;
        cap_mdata = ~pc;
        cap_halt  = halt;
    endtask

    task automatic checkOutputs();
        rec_t             eRec;
        logic [CNT_W-1:0] eCyc;
        eRec = (expQ.size() != 0) ? expQ[0] : '0;
        eCyc = '0;
`ifdef COMMIT_CYCLE_STAMP_EN
        if (expCycQ.size() != 0) eCyc = expCycQ[0];
`endif
        check("out_valid", 128'(out_valid), 128'(expQ.size() != 0));
        check("out_rec",   128'(out_rec),   128'(eRec));
        check("out_cycle", 128'(out_cycle), 128'(eCyc));
        check("overflow",  128'(overflow),  128'(mOvf));
        check("done",      128'(done),      128'(mState == DONE));
    endtask

    // Checks outputs mid-cycle, advances the model over the coming edge,
    // then returns just after that edge so the caller can drive new inputs.
    task automatic tick();
        int unsigned preSize;
        logic        doPop;
        state_t      nSt;
        rec_t        r;
        @(negedge clk);
        checkOutputs();
        preSize = expQ.size();
        doPop   = out_ready && (preSize != 0);
        nSt     = mState;
        if (mState == RUN && cap_en && cap_halt) nSt = DRAIN;
        else if (mState == DRAIN && preSize == 0) nSt = DONE;
        if (doPop) begin
            void'(expQ.pop_front());
            void'(expCycQ.pop_front());
        end
        if (mState == RUN && cap_en) begin
            r       = '0;
            r.pc    = cap_pc;    r.inst  = cap_inst;
            r.regwr = cap_regwr; r.wreg  = cap_wreg;  r.wdata = cap_wdata;
            r.memrd = cap_memrd; r.memwr = cap_memwr;
            r.addr  = cap_addr;  r.mdata = cap_mdata; r.halt  = cap_halt;
            r.inum  = mInum;
            if (preSize < DEPTH || doPop) begin
                expQ.push_back(r);
                expCycQ.push_back(mCycle);
            end else begin
                mOvf = 1'b1;
            end
            mInum = mInum + 1'b1;
        end
        mState = nSt;
        mCycle = mCycle + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        setIdle();
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_rec",   128'(out_rec),   128'(0));
        check("rst_overflow",  128'(overflow),  128'(0));
        check("rst_done",      128'(done),      128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expQ.delete();
        expCycQ.delete();
        mInum  = '0;
        mOvf   = 1'b0;
        mState = RUN;
        @(posedge clk);
        #1;
        mCycle = 1;
    endtask

    task automatic drain(input int unsigned n);
        setIdle();
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        // 1: three ALU records streamed back-to-back with the consumer ready.
        resetDut();
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            setCap(16'h0100 + 16'(i * 2), 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drain(3);

        // 2: consumer stalled, DEPTH+2 captures; two drop, then inum 10 follows.
        resetDut();
        out_ready = 1'b0;
        for (int unsigned i = 0; i < DEPTH + 2; i++) begin
            setCap(16'h0200 + 16'(i), 16'h2000 + 16'(i), 1'b0, i[0], ~i[0], 1'b0);
            tick();
        end
        setIdle();
        tick();
        drain(DEPTH);
        setCap(16'h02ff, 16'h2abc, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drain(2);
        check("gap_inum", 128'(mInum), 128'(11));

        // 3: full FIFO with push and pop in the same cycles: nothing dropped.
        resetDut();
        out_ready = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            setCap(16'h0300 + 16'(i), 16'h3000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            setCap(16'h0380 + 16'(i), 16'h3800 + 16'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("full_occupancy", 128'(expQ.size()), 128'(DEPTH));
        drain(DEPTH + 1);

        // 4: halt at inum 5, later captures ignored, done after the last pop.
        resetDut();
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            setCap(16'h0400 + 16'(i), 16'h4000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        setCap(16'h0405, 16'hf000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            setCap(16'h0480 + 16'(i), 16'h4800 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drain(10);

        // 5: reset while draining with 4 entries; numbering restarts at 0.
        resetDut();
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            setCap(16'h0500 + 16'(i), 16'h5000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        setCap(16'h0503, 16'hf000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        setIdle();
        tick();
        resetDut();
        out_ready = 1'b1;
        setCap(16'h0510, 16'h5100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drain(2);

        // 6: captures stamped at cycles 3 and 7.
        resetDut();
        out_ready = 1'b0;
        while (mCycle != 3) tick();
        setCap(16'h0600, 16'h6000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        setIdle();
        while (mCycle != 7) tick();
        setCap(16'h0604, 16'h6004, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drain(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
